grid_renderer: RTL and testbench

- Parametrised, pipelined successor to the fixed 4x4 cell display.
- Maps VGA pixel coordinates onto a GRID_COLS x GRID_ROWS Game of Life board of 2^CELL_LOG2-pixel square cells.
- Reads cell state from an external synchronous cell RAM and emits registered 12-bit RGB, with sync signals delayed to stay aligned.
- Adds a frame-counted blinking cursor for the board editor; sits between the VGA timing generator and the DAC pins.

---
 rtl/grid_renderer_if.sv | 10 +
 rtl/grid_renderer.sv | 133 +++++++++++++
 tb/tb_grid_renderer.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/grid_renderer_if.sv
// Cell RAM read bus between grid_renderer (master) and the external synchronous cell RAM (slave).
interface grid_renderer_if #(
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] cell_addr;
   logic              cell_alive;

   modport master (output cell_addr, input  cell_alive);
   modport slave  (input  cell_addr, output cell_alive);
endinterface

// File: rtl/grid_renderer.sv
// Two-stage pixel pipeline mapping VGA coordinates onto a Game of Life board with a blinking cursor.
// Optional macro GRID_LINES_EN draws cell borders in GRID_RGB over cursor and cell colours.
module grid_renderer #(
   parameter int          GRID_COLS    = 16,
   parameter int          GRID_ROWS    = 16,
   parameter int          CELL_LOG2    = 5,
   parameter int          BLINK_FRAMES = 30,
   parameter logic [11:0] ALIVE_RGB    = 12'hFFF,
   parameter logic [11:0] DEAD_RGB     = 12'h000,
   parameter logic [11:0] CURSOR_RGB   = 12'hF00
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [10:0] x,
   input  logic [10:0] y,
   input  logic        de,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        frame_start,
   input  logic        cursor_en,
   input  logic [5:0]  cursor_col,
   input  logic [5:0]  cursor_row,
   grid_renderer_if.master ram,
   output logic [11:0] rgb,
   output logic        hsync_out,
   output logic        vsync_out
);

   localparam int ADDR_W = (GRID_COLS * GRID_ROWS > 1) ? $clog2(GRID_COLS * GRID_ROWS) : 1;
   localparam int CNT_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [10:0]       col;
   logic [10:0]       row;
   logic              in_grid;
   logic              cursor_hit;
   logic [ADDR_W-1:0] lin_addr;

   logic              s1_in_grid;
   logic              s1_cursor;
   logic              s1_hsync;
   logic              s1_vsync;
   logic [11:0]       pix_rgb;

   logic [CNT_W-1:0]  blink_cnt;
   logic              blink_phase;

`ifdef GRID_LINES_EN
   localparam logic [11:0] GRID_RGB = 12'h444;
   localparam logic [10:0] LAST_X   = 11'((GRID_COLS << CELL_LOG2) - 1);
   localparam logic [10:0] LAST_Y   = 11'((GRID_ROWS << CELL_LOG2) - 1);
   logic border;
   logic s1_border;
`endif

   // Full-width compares keep coordinates past the board from aliasing back onto it.
   always_comb begin
      col        = x >> CELL_LOG2;
      row        = y >> CELL_LOG2;
      in_grid    = de && (col < 11'(GRID_COLS)) && (row < 11'(GRID_ROWS));
      cursor_hit = cursor_en && (col == {5'd0, cursor_col}) && (row == {5'd0, cursor_row});
      lin_addr   = ADDR_W'(row[5:0]) * ADDR_W'(GRID_COLS) + ADDR_W'(col[5:0]);
   end

   assign ram.cell_addr = in_grid ? lin_addr : '0;

`ifdef GRID_LINES_EN
   assign border = in_grid && ((x[CELL_LOG2-1:0] == '0) || (y[CELL_LOG2-1:0] == '0) ||
                               (x == LAST_X) || (y == LAST_Y));
`endif

   // Stage 1 holds the per-pixel flags while the RAM read is in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_in_grid <= 1'b0;
         s1_cursor  <= 1'b0;
         s1_hsync   <= 1'b1;
         s1_vsync   <= 1'b1;
`ifdef GRID_LINES_EN
         s1_border  <= 1'b0;
`endif
      end else begin
         s1_in_grid <= in_grid;
         s1_cursor  <= cursor_hit;
         s1_hsync   <= hsync_in;
         s1_vsync   <= vsync_in;
`ifdef GRID_LINES_EN
         s1_border  <= border;
`endif
      end
   end

   always_comb begin
      pix_rgb = DEAD_RGB;
      if (!s1_in_grid)
         pix_rgb = 12'h000;
`ifdef GRID_LINES_EN
      else if (s1_border)
         pix_rgb = GRID_RGB;
`endif
      else if (s1_cursor && blink_phase)
         pix_rgb = CURSOR_RGB;
      else if (ram.cell_alive)
         pix_rgb = ALIVE_RGB;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rgb       <= 12'h000;
         hsync_out <= 1'b1;
         vsync_out <= 1'b1;
      end else begin
         rgb       <= pix_rgb;
         hsync_out <= s1_hsync;
         vsync_out <= s1_vsync;
      end
   end

   // Cursor blink half-period is counted in frames, not pixels.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (frame_start) begin
         if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_grid_renderer.sv
// Randomised bench for grid_renderer against a coordinate-level model of the board renderer.
module tb_grid_renderer;

   localparam int COLS   = 16;
   localparam int ROWS   = 16;
   localparam int CL     = 5;
   localparam int CELL   = 1 << CL;
   localparam int BLINK  = 2;
   localparam int ADDR_W = 8;

   typedef struct {
      logic [11:0] rgb;
      logic        hs;
      logic        vs;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [10:0] x = '0;
   logic [10:0] y = '0;
   logic        de = 1'b0;
   logic        hsync_in = 1'b1;
   logic        vsync_in = 1'b1;
   logic        frame_start = 1'b0;
   logic        cur_en = 1'b0;
   logic [5:0]  cur_col = '0;
   logic [5:0]  cur_row = '0;
   logic [11:0] rgb;
   logic        hsync_out;
   logic        vsync_out;

   grid_renderer_if #(.ADDR_W(ADDR_W)) ram ();

   grid_renderer #(
      .GRID_COLS(COLS), .GRID_ROWS(ROWS), .CELL_LOG2(CL), .BLINK_FRAMES(BLINK),
      .ALIVE_RGB(12'hFFF), .DEAD_RGB(12'h000), .CURSOR_RGB(12'hF00)
   ) dut (
      .clk(clk), .rst_n(rst_n), .x(x), .y(y), .de(de),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .frame_start(frame_start),
      .cursor_en(cur_en), .cursor_col(cur_col), .cursor_row(cur_row),
      .ram(ram.master), .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out)
   );

   always #5 clk = ~clk;

   // Synchronous cell RAM model: one-cycle read latency.
   logic mem [0:COLS*ROWS-1];
   always @(posedge clk) ram.cell_alive <= mem[ram.cell_addr];

   int   checks = 0;
   int   failures = 0;
   int   pulses = 0;
   exp_t pipe[$];

   bit              obs_valid;
   logic [11:0]     obs_rgb, exp_rgb;
   logic            obs_hs, exp_hs, obs_vs, exp_vs;
   logic [ADDR_W-1:0] obs_addr, exp_addr;

   function automatic bit model_phase();
      return ((pulses / BLINK) % 2) == 1;
   endfunction

   function automatic logic [11:0] model_rgb(int px, int py, bit pde);
      int c;
      int r;
      c = px / CELL;
      r = py / CELL;
      if (!pde || c >= COLS || r >= ROWS) return 12'h000;
`ifdef GRID_LINES_EN
      if ((px % CELL) == 0 || (py % CELL) == 0 || px == COLS*CELL-1 || py == ROWS*CELL-1)
         return 12'h444;
`endif
      if (cur_en && c == int'(cur_col) && r == int'(cur_row) && model_phase()) return 12'hF00;
      return mem[r*COLS+c] ? 12'hFFF : 12'h000;
   endfunction

   function automatic logic [ADDR_W-1:0] model_addr(int px, int py, bit pde);
      int c;
      int r;
      c = px / CELL;
      r = py / CELL;
      if (!pde || c >= COLS || r >= ROWS) return '0;
      return ADDR_W'(r*COLS + c);
   endfunction

   // One pixel clock: capture what left the pipeline, drive the next pixel, record its expectation.
   task automatic step_pixel(input int px, input int py, input bit pde,
                             input bit phs, input bit pvs, input bit pfs);
      exp_t e;
      @(posedge clk);
      #1;
      obs_valid = 1'b0;
      if (pipe.size() == 2) begin
         e         = pipe.pop_front();
         obs_valid = 1'b1;
         obs_rgb   = rgb;
         obs_hs    = hsync_out;
         obs_vs    = vsync_out;
         exp_rgb   = e.rgb;
         exp_hs    = e.hs;
         exp_vs    = e.vs;
      end
      x = 11'(px);
      y = 11'(py);
      de = pde;
      hsync_in = phs;
      vsync_in = pvs;
      frame_start = pfs;
      if (pfs) pulses++;
      e.rgb = model_rgb(px, py, pde);
      e.hs  = phs;
      e.vs  = pvs;
      pipe.push_back(e);
      exp_addr = model_addr(px, py, pde);
      #1;
      obs_addr = ram.cell_addr;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < COLS*ROWS; i++) mem[i] = 1'b0;
   endtask

   task automatic test_reset();
      clear_mem();
      #1;
      rst_n = 1'b0;
      de = 1'b1; x = 11'd40; y = 11'd40; hsync_in = 1'b0; vsync_in = 1'b0;
      #1;
      checks++;
      if (rgb !== 12'h000 || hsync_out !== 1'b1 || vsync_out !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_state got rgb=%h hs=%b vs=%b want rgb=000 hs=1 vs=1", rgb, hsync_out, vsync_out);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (rgb !== 12'h000 || hsync_out !== 1'b1 || vsync_out !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_hold got rgb=%h hs=%b vs=%b want rgb=000 hs=1 vs=1", rgb, hsync_out, vsync_out);
      end
      rst_n = 1'b1;
      pipe.delete();
      pulses = 0;
   endtask

   task automatic test_cell_colour();
      mem[17] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i == 3) mem[17] = 1'b0;
         if (i < 6) step_pixel((i == 2 || i == 5) ? 0 : 40, 40, i != 2 && i != 5, 1, 1, 0);
         else step_pixel(0, 0, 0, 1, 1, 0);
         if (i < 6) begin
            checks++;
            if (obs_addr !== exp_addr) begin
               failures++;
               $display("[TB] FAIL cell_addr got=%0d want=%0d", obs_addr, exp_addr);
            end
         end
         if (obs_valid) begin
            checks++;
            if (obs_rgb !== exp_rgb) begin
               failures++;
               $display("[TB] FAIL cell_rgb step=%0d got=%h want=%h", i, obs_rgb, exp_rgb);
            end
         end
      end
   endtask

   task automatic test_out_of_grid();
      int px[7] = '{600, 40, 40, 511, 512, 511, 2047};
      int py[7] = '{40, 40, 600, 511, 511, 512, 2047};
      bit pd[7] = '{1, 0, 1, 1, 1, 1, 1};
      mem[255] = 1'b1;
      mem[17] = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (i < 7) step_pixel(px[i], py[i], pd[i], 0, 1, 0);
         else step_pixel(0, 0, 0, 1, 1, 0);
         if (i < 7) begin
            checks++;
            if (obs_addr !== exp_addr) begin
               failures++;
               $display("[TB] FAIL edge_addr idx=%0d got=%0d want=%0d", i, obs_addr, exp_addr);
            end
         end
         if (obs_valid) begin
            checks++;
            if (obs_rgb !== exp_rgb || obs_hs !== exp_hs) begin
               failures++;
               $display("[TB] FAIL edge_rgb step=%0d got=%h/%b want=%h/%b", i, obs_rgb, obs_hs, exp_rgb, exp_hs);
            end
         end
      end
      mem[255] = 1'b0;
      mem[17] = 1'b0;
   endtask

   // Phase toggles every BLINK pulses; with BLINK=2 the cursor is lit after pulses 2,3 and from 6.
   task automatic test_blink();
      logic [11:0] plan;
      cur_en = 1'b1; cur_col = 6'd1; cur_row = 6'd1;
      mem[17] = 1'b0;
      for (int p = 1; p <= 7; p++) begin
         for (int k = 0; k < 4; k++) begin
            step_pixel(40, 40, 1, 1, 1, k == 0);
            if (obs_valid) begin
               checks++;
               if (obs_rgb !== exp_rgb) begin
                  failures++;
                  $display("[TB] FAIL blink_model pulse=%0d got=%h want=%h", p, obs_rgb, exp_rgb);
               end
            end
         end
         plan = (p == 2 || p == 3 || p >= 6) ? 12'hF00 : 12'h000;
         checks++;
         if (obs_rgb !== plan) begin
            failures++;
            $display("[TB] FAIL blink_plan pulse=%0d got=%h want=%h", p, obs_rgb, plan);
         end
      end
      repeat (2) step_pixel(0, 0, 0, 1, 1, 0);
   endtask

   task automatic test_sync_random();
      repeat (2) step_pixel(0, 0, 0, 1, 1, 0);
      for (int i = 0; i < COLS*ROWS; i++) mem[i] = 1'($urandom);
      for (int i = 0; i < 300; i++) begin
         cur_en  = 1'($urandom);
         cur_col = 6'($urandom_range(0, 17));
         cur_row = 6'($urandom_range(0, 17));
         if (i < 298)
            step_pixel((i % 10 == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, 700)),
                       int'($urandom_range(0, 600)), ($urandom_range(0, 5) != 0),
                       1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0));
         else
            step_pixel(0, 0, 0, 1, 1, 0);
         if (i < 298) begin
            checks++;
            if (obs_addr !== exp_addr) begin
               failures++;
               $display("[TB] FAIL rand_addr i=%0d got=%0d want=%0d", i, obs_addr, exp_addr);
            end
         end
         if (obs_valid) begin
            checks++;
            if (obs_rgb !== exp_rgb || obs_hs !== exp_hs || obs_vs !== exp_vs) begin
               failures++;
               $display("[TB] FAIL rand_pixel i=%0d got rgb=%h hs=%b vs=%b want rgb=%h hs=%b vs=%b",
                        i, obs_rgb, obs_hs, obs_vs, exp_rgb, exp_hs, exp_vs);
            end
         end
      end
      cur_en = 1'b0;
   endtask

   task automatic test_grid_lines();
      logic [11:0] want;
      clear_mem();
      mem[17] = 1'b1;
      cur_en = 1'b1; cur_col = 6'd1; cur_row = 6'd1;
      for (int n = 0; n < 2*BLINK && !model_phase(); n++) step_pixel(0, 0, 0, 1, 1, 1);
`ifdef GRID_LINES_EN
      want = 12'h444;
`else
      want = 12'hF00;
`endif
      for (int i = 0; i < 5; i++) begin
         step_pixel(i < 3 ? 32 : 40, 40, 1, 1, 1, 0);
         if (obs_valid) begin
            checks++;
            if (obs_rgb !== exp_rgb) begin
               failures++;
               $display("[TB] FAIL grid_model i=%0d got=%h want=%h", i, obs_rgb, exp_rgb);
            end
         end
      end
      checks++;
      if (obs_rgb !== want) begin
         failures++;
         $display("[TB] FAIL grid_line_pixel got=%h want=%h", obs_rgb, want);
      end
      repeat (2) step_pixel(40, 40, 1, 1, 1, 0);
      checks++;
      if (obs_rgb !== 12'hF00) begin
         failures++;
         $display("[TB] FAIL grid_inner_pixel got=%h want=F00", obs_rgb);
      end
   endtask

   task automatic test_reset_mid_stream();
      mem[17] = 1'b0;
      cur_en = 1'b1; cur_col = 6'd1; cur_row = 6'd1;
      for (int n = 0; n < 2*BLINK && !model_phase(); n++) step_pixel(40, 40, 1, 0, 0, 1);
      repeat (3) step_pixel(40, 40, 1, 0, 0, 0);
      checks++;
      if (obs_rgb !== 12'hF00 || obs_hs !== 1'b0) begin
         failures++;
         $display("[TB] FAIL pre_reset got rgb=%h hs=%b want rgb=F00 hs=0", obs_rgb, obs_hs);
      end
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (rgb !== 12'h000 || hsync_out !== 1'b1 || vsync_out !== 1'b1) begin
         failures++;
         $display("[TB] FAIL async_reset got rgb=%h hs=%b vs=%b want rgb=000 hs=1 vs=1", rgb, hsync_out, vsync_out);
      end
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      pipe.delete();
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         step_pixel(40, 40, 1, 0, 0, 0);
         if (obs_valid) begin
            checks++;
            if (obs_rgb !== exp_rgb || obs_hs !== exp_hs) begin
               failures++;
               $display("[TB] FAIL post_reset i=%0d got rgb=%h hs=%b want rgb=%h hs=%b",
                        i, obs_rgb, obs_hs, exp_rgb, exp_hs);
            end
         end
      end
      checks++;
      if (obs_rgb !== 12'h000) begin
         failures++;
         $display("[TB] FAIL post_reset_phase got=%h want=000", obs_rgb);
      end
   endtask

   initial begin
      test_reset();
      test_cell_colour();
      test_out_of_grid();
      test_blink();
      test_sync_random();
      test_grid_lines();
      test_reset_mid_stream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
